// File: rtl/fpu_pkg.sv
// Shared single-precision definitions for the FPU datapath blocks.
// Contents: field widths, exponent bias, canonical quiet NaN, the fp32_t
// field view, a special-operand class used inside the adder pipeline, and
// NaN/Inf classifiers.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Result class decided from the operands alone, before any arithmetic.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2
  } special_e;

  function automatic logic is_nan(input fp32_t f);
    return (f.exp == '1) && (f.man != '0);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (f.exp == '1) && (f.man == '0);
  endfunction

endpackage

// File: rtl/lzc25.sv
// Combinational leading-zero counter for the adder's normalize stage.
// Ports:
//   val_i  [24:0]  value to scan (bit 24 is the most significant)
//   cnt_o  [4:0]   number of leading zeros, 25 when val_i is all zero
module lzc25 (
  input  logic [24:0] val_i,
  output logic [4:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last to write cnt_o.
  always_comb begin
    cnt_o = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (val_i[i]) cnt_o = 5'(24 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage pipelined IEEE-754 single-precision adder, y = x1 + x2,
// round-to-nearest-even, with valid/ready handshakes and a sideband tag.
//   S1: unpack, order operands so |a| >= |b|, exponent difference, specials
//   S2: align b (guard/round/sticky), add or subtract magnitudes
//   S3: leading-zero count, normalize, round, pack, overflow flag
// The whole pipeline holds while the output is valid and not accepted.
// Build option: define FADD_SUB_EN to add the 'sub' input (x1 - x2).
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_valid/in_ready    operand handshake; x1, x2, in_tag (and sub)
//   out_valid/out_ready  result handshake; y, ovf, out_tag
module fadd_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
`ifdef FADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------- S1: unpack and order ----------------
  fp32_t    op1, op2, a_d, b_d;
  logic     swap_d;
  logic [7:0]  ea_d, eb_d, diff_d;
  logic [23:0] ma_d, mb_d;
  special_e sp_d;

  assign op1 = x1;
`ifdef FADD_SUB_EN
  assign op2 = {x2[31] ^ sub, x2[30:0]};
`else
  assign op2 = x2;
`endif

  always_comb begin
    // Exponent-then-mantissa compare is a plain magnitude compare.
    swap_d = op2[30:0] > op1[30:0];
    a_d    = swap_d ? op2 : op1;
    b_d    = swap_d ? op1 : op2;
    ea_d   = (a_d.exp == '0) ? 8'd1 : a_d.exp;
    eb_d   = (b_d.exp == '0) ? 8'd1 : b_d.exp;
    ma_d   = {a_d.exp != '0, a_d.man};
    mb_d   = {b_d.exp != '0, b_d.man};
    diff_d = ea_d - eb_d;
    sp_d   = SP_NONE;
    if (is_nan(op1) || is_nan(op2) ||
        (is_inf(op1) && is_inf(op2) && (op1.sign != op2.sign)))
      sp_d = SP_NAN;
    else if (is_inf(op1) || is_inf(op2))
      sp_d = SP_INF;
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q;
  logic [7:0]       s1_exp_q, s1_diff_q;
  logic [23:0]      s1_ma_q, s1_mb_q;
  special_e         s1_sp_q;
  logic [TAG_W-1:0] s1_tag_q;

  // ---------------- S2: align and add ----------------
  logic [26:0] b_ext, b_shift, a_al, b_al;
  logic        b_lost;
  logic [27:0] sum_d;

  always_comb begin
    b_ext = {s1_mb_q, 3'b000};
    if (s1_diff_q >= 8'd26) begin
      b_shift = '0;
      b_lost  = |s1_mb_q;
    end else begin
      b_shift = b_ext >> s1_diff_q;
      b_lost  = |(b_ext & ((27'd1 << s1_diff_q) - 27'd1));
    end
    b_al  = {b_shift[26:1], b_shift[0] | b_lost};
    a_al  = {s1_ma_q, 3'b000};
    sum_d = s1_sub_q ? ({1'b0, a_al} - {1'b0, b_al})
                     : ({1'b0, a_al} + {1'b0, b_al});
  end

  logic             s2_valid_q, s2_sign_q, s2_sub_q;
  logic [7:0]       s2_exp_q;
  logic [27:0]      s2_sum_q;
  special_e         s2_sp_q;
  logic [TAG_W-1:0] s2_tag_q;

  // ---------------- S3: normalize, round, pack ----------------
  logic [4:0]  lz, sh;
  logic [26:0] norm;
  logic [8:0]  exp9;
  logic        round_up;
  logic [31:0] rnd;
  logic [31:0] y_d;
  logic        ovf_d;

  // A nonzero sum with the top 25 bits clear can only be 4 (one-bit-apart
  // cancellation), which a saturated count of 25 normalizes correctly.
  lzc25 u_lzc (
    .val_i (s2_sum_q[27:3]),
    .cnt_o (lz)
  );

  always_comb begin
    sh   = 5'd0;
    norm = s2_sum_q[26:0];
    exp9 = {1'b0, s2_exp_q};
    if (lz == 5'd0) begin
      norm = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      exp9 = {1'b0, s2_exp_q} + 9'd1;
    end else begin
      sh = lz - 5'd1;
      // Stop at effective exponent 1; what remains is a subnormal.
      if ({3'b000, sh} >= s2_exp_q) sh = 5'(s2_exp_q - 8'd1);
      norm = 27'(s2_sum_q << sh);
      exp9 = norm[26] ? ({1'b0, s2_exp_q} - {4'b0000, sh}) : 9'd0;
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Mantissa carry ripples into the exponent (also subnormal -> normal).
    rnd   = {exp9, norm[25:3]} + {31'd0, round_up};
    y_d   = {s2_sign_q, rnd[30:0]};
    ovf_d = 1'b0;
    case (s2_sp_q)
      SP_NAN:  y_d = QNAN;
      SP_INF:  y_d = {s2_sign_q, 8'hFF, 23'd0};
      default: begin
        if (s2_sum_q == '0) begin
          // Only like-signed zeros reach here via an addition.
          y_d = {s2_sign_q & ~s2_sub_q, 31'd0};
        end else if (rnd[31:23] >= 9'd255) begin
          y_d   = {s2_sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_diff_q  <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_sp_q    <= SP_NONE;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_sp_q    <= SP_NONE;
      s2_tag_q   <= '0;
      out_valid  <= 1'b0;
      y          <= '0;
      ovf        <= 1'b0;
      out_tag    <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= a_d.sign;
      s1_sub_q   <= a_d.sign ^ b_d.sign;
      s1_exp_q   <= ea_d;
      s1_diff_q  <= diff_d;
      s1_ma_q    <= ma_d;
      s1_mb_q    <= mb_d;
      s1_sp_q    <= sp_d;
      s1_tag_q   <= in_tag;
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_sub_q   <= s1_sub_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= sum_d;
      s2_sp_q    <= s1_sp_q;
      s2_tag_q   <= s1_tag_q;
      out_valid  <= s2_valid_q;
      y          <= y_d;
      ovf        <= ovf_d;
      out_tag    <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Self-checking bench for fadd_pipe: table of operand pairs with expected
// sums, a scoreboard queue matching results to accepted inputs, plus
// hand-written latency, backpressure and reset-flush sequences.
module tb_fadd_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic [4:0]  tag;
  } exp_t;

  logic        clk, rstn;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x1, x2, y;
  logic [4:0]  in_tag, out_tag;
`ifdef FADD_SUB_EN
  logic        sub;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  exp_t sb_q[$];
  exp_t cur_exp;
  logic in_fire;
  logic prev_stall = 1'b0;
  logic [31:0] hold_y;
  logic        hold_ovf;
  logic [4:0]  hold_tag;
  vec_t tbl[24];

  fadd_pipe #(.TAG_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
`ifdef FADD_SUB_EN
    .sub       (sub),
`endif
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; samples, scores,
  // then advances to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    in_fire = in_valid && in_ready;
    if (prev_stall) begin
      n_tests++;
      if ({out_valid, y, ovf, out_tag} !== {1'b1, hold_y, hold_ovf, hold_tag}) begin
        n_fail++;
        $display("FAIL stall hold: got v=%0b y=%08h ovf=%0b tag=%0d expected v=1 y=%08h ovf=%0b tag=%0d",
                 out_valid, y, ovf, out_tag, hold_y, hold_ovf, hold_tag);
      end
    end
    if (out_valid && out_ready) begin
      n_pops++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL result: got y=%08h tag=%0d expected no pending result", y, out_tag);
      end else begin
        e = sb_q.pop_front();
        if ({y, ovf, out_tag} !== {e.y, e.ovf, e.tag}) begin
          n_fail++;
          $display("FAIL result: got y=%08h ovf=%0b tag=%0d expected y=%08h ovf=%0b tag=%0d",
                   y, ovf, out_tag, e.y, e.ovf, e.tag);
        end
      end
    end
    if (out_valid && !out_ready) begin
      check("in_ready while stalled", {31'd0, in_ready}, 32'd0);
      hold_y = y; hold_ovf = ovf; hold_tag = out_tag;
      prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
    if (in_fire) sb_q.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int idx, input logic [4:0] tag);
    in_valid = 1'b1;
    x1 = tbl[idx].a;
    x2 = tbl[idx].b;
    in_tag = tag;
    cur_exp = '{y: tbl[idx].y, ovf: tbl[idx].ovf, tag: tag};
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && n < 40) begin
      cycle();
      n++;
    end
    check("drain pending count", sb_q.size(), 32'd0);
  endtask

  initial begin
    int lat;
    int k;
    int cyc;
    logic seen;
    logic [3:0] rdy_pat;

    tbl[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
    tbl[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
    tbl[2]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0};
    tbl[3]  = '{32'h3F800001, 32'hBF800000, 32'h34000000, 1'b0};
    tbl[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0};
    tbl[5]  = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0};
    tbl[6]  = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
    tbl[7]  = '{32'h00400000, 32'h00400000, 32'h00800000, 1'b0};
    tbl[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0};
    tbl[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0};
    tbl[10] = '{32'h7F800001, 32'h7F800000, 32'h7FC00000, 1'b0};
    tbl[11] = '{32'h40400000, 32'hBF800000, 32'h40000000, 1'b0};
    tbl[12] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0};
    tbl[13] = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0};
    tbl[14] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1};
    tbl[15] = '{32'h00800000, 32'h80000001, 32'h007FFFFF, 1'b0};
    tbl[16] = '{32'h4B000000, 32'h3F000000, 32'h4B000000, 1'b0};
    tbl[17] = '{32'h3F800000, 32'h00000001, 32'h3F800000, 1'b0};
    tbl[18] = '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0};
    tbl[19] = '{32'h01000000, 32'h80FFFFFF, 32'h00000001, 1'b0};
    tbl[20] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0};
    tbl[21] = '{32'hBF800000, 32'h40000000, 32'h3F800000, 1'b0};
    tbl[22] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1};
    tbl[23] = '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x1 = '0; x2 = '0; in_tag = '0;
`ifdef FADD_SUB_EN
    sub = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset y", y, 32'd0);
    check("reset ovf/tag", {26'd0, ovf, out_tag}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // Latency: capture edge plus two more edges
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40000000; in_tag = 5'h15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency edges after capture", lat, 32'd2);
    check("latency y", y, 32'h40400000);
    check("latency ovf/tag", {26'd0, ovf, out_tag}, {26'd0, 1'b0, 5'h15});
    @(posedge clk);
    #1;
    check("single result not repeated", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Table streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      set_op(i, 5'(i));
      cycle();
    end
    drain();

    // Backpressure: 8 ops, out_ready pattern 1,0,0,1
    rdy_pat = 4'b1001;
    n_pops = 0;
    prev_stall = 1'b0;
    k = 0;
    cyc = 0;
    while ((k < 8 || sb_q.size() != 0 || out_valid) && cyc < 200) begin
      if (k < 8) set_op(k, 5'(k));
      else in_valid = 1'b0;
      out_ready = rdy_pat[3 - (cyc % 4)];
      cycle();
      if (in_fire) k++;
      cyc++;
    end
    check("backpressure ops accepted", k, 32'd8);
    check("backpressure results seen", n_pops, 32'd8);
    drain();

    // Reset with three ops in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(i, 5'(i + 20));
      cycle();
    end
    in_valid = 1'b0;
    #1;
    check("ops in flight before reset", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("reset flush out_valid", {31'd0, out_valid}, 32'd0);
    check("reset flush y", y, 32'd0);
    sb_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no stale result after reset", {31'd0, seen}, 32'd0);
    @(negedge clk);

`ifdef FADD_SUB_EN
    sub = 1'b1;
    tbl[0] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0};
    tbl[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0};
    tbl[2] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0};
    tbl[3] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1};
    for (int i = 0; i < 4; i++) begin
      set_op(i, 5'(i + 8));
      cycle();
    end
    drain();
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
